// File: rtl/ads_pkg.sv
// Shared definitions for the ADS front-end configuration sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ads_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PWR_WAIT = 3'd1,
        RST_LOW  = 3'd2,
        RST_WAIT = 3'd3,
        CFG      = 3'd4,
        ID_RD    = 3'd5,
        START    = 3'd6,
        RUN      = 3'd7
    } state_t;

    // ADC command opcodes; WREG/RREG are OR-ed with the register address
    localparam logic [7:0] SDATAC = 8'h11;
    localparam logic [7:0] RDATAC = 8'h10;
    localparam logic [7:0] WREG   = 8'h40;
    localparam logic [7:0] RREG   = 8'h20;

    localparam int         ROM_LEN  = 18;
    localparam logic [3:0] STAT_HDR = 4'hC;

endpackage

// File: rtl/ads_cfg_seq_if.sv
// Byte-transfer link between the sequencer and the SPI shifter.
// Latency: n/a (wires only).
// Backpressure: spi_req is held until the shifter answers with spi_done.
interface ads_cfg_seq_if;
    logic       spi_req;
    logic [7:0] spi_tx;
    logic       spi_done;
    logic [7:0] spi_rx;

    modport master (output spi_req, output spi_tx, input spi_done, input spi_rx);
    modport slave  (input spi_req, input spi_tx, output spi_done, output spi_rx);
endinterface

// File: rtl/ads_cfg_rom.sv
// Power-up register script for the ADC: stop continuous read, write config, read ID.
// Latency: combinational.
// Backpressure: none.
module ads_cfg_rom
    import ads_pkg::*;
(
    input  logic [4:0] idx,
    output logic [7:0] dat
);

    // Script lookup; out-of-range indices read as 00
    always_comb begin
        dat = 8'h00;
        case (idx)
            5'd0:  dat = SDATAC;
            5'd1:  dat = WREG | 8'h01;   // write starting at CONFIG1
            5'd2:  dat = 8'h02;          // three registers
            5'd3:  dat = 8'hD6;
            5'd4:  dat = 8'hE3;
            5'd5:  dat = 8'h40;
            5'd6:  dat = WREG | 8'h05;   // write starting at CH1SET
            5'd7:  dat = 8'h07;          // eight channel registers
            5'd8:  dat = 8'h10;
            5'd9:  dat = 8'h10;
            5'd10: dat = 8'h10;
            5'd11: dat = 8'h10;
            5'd12: dat = 8'h10;
            5'd13: dat = 8'h10;
            5'd14: dat = 8'h10;
            5'd15: dat = 8'h10;
            5'd16: dat = RREG | 8'h00;   // read ID register
            5'd17: dat = 8'h00;
            default: dat = 8'h00;
        endcase
    end

endmodule

// File: rtl/ads_cfg_seq.sv
// ADC bring-up sequencer (power, reset, register script, ID read) then DRDY-driven frame reader.
// Latency: ch_valid/status update one cycle after the spi_done of the word's third byte.
// Backpressure: each byte waits on spi_done, then exactly BYTE_GAP idle cycles; optional ADS_STATUS_CHECK_EN adds stat_err.
module ads_cfg_seq
    import ads_pkg::*;
#(
    parameter logic [20:0] T_PWR       = 21'h1FFFFF,
    parameter logic [20:0] T_RST_LOW   = 21'h100,
    parameter logic [20:0] T_RST_WAIT  = 21'h10000,
    parameter int          BYTE_GAP    = 16,
    parameter int          FRAME_BYTES = 27
) (
    input  logic          clk_50M,
    input  logic          rst,
    input  logic          ads_drdy_n,
    output logic          ads_cs_n,
    output logic          ads_start,
    output logic          ads_reset_n,
    output logic          ads_pwdn_n,
    ads_cfg_seq_if.master spi,
    output logic          init_done,
    output logic [7:0]    dev_id,
    output logic [23:0]   ch_data,
    output logic [2:0]    ch_idx,
    output logic          ch_valid,
    output logic [23:0]   status,
    output logic          overrun
`ifdef ADS_STATUS_CHECK_EN
    ,
    output logic          stat_err
`endif
);

    localparam logic [20:0] GAP_M1   = 21'(BYTE_GAP - 1);
    localparam logic [4:0]  LAST_ROM = 5'(ROM_LEN - 1);
    localparam logic [4:0]  LAST_FB  = 5'(FRAME_BYTES - 1);

    state_t      state;
    logic [20:0] cnt;
    logic [4:0]  byte_idx;
    logic [1:0]  grp;        // byte position inside the current 24-bit word
    logic [3:0]  word;       // 0 = status word, k = channel k-1
    logic        frame_act;
    logic [15:0] sh;         // first two bytes of the word being assembled
    logic [2:0]  drdy_sync;
    logic        drdy_fall;
    logic [7:0]  rom_dat;
    logic        xfer_done;
    logic        gap_hit;

    ads_cfg_rom u_rom (
        .idx (byte_idx),
        .dat (rom_dat)
    );

    // A done pulse only counts while a request is outstanding
    assign xfer_done = spi.spi_req & spi.spi_done;
    // Next byte may go out once the idle gap after the previous done has elapsed
    assign gap_hit   = ~spi.spi_req & (cnt == GAP_M1);
    assign drdy_fall = drdy_sync[2] & ~drdy_sync[1];

    // Two-flop synchroniser on DRDY plus one history flop for edge detection
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) drdy_sync <= 3'b111;
        else     drdy_sync <= {drdy_sync[1:0], ads_drdy_n};
    end

    // Sequencer FSM with registered pin, SPI and result outputs
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            byte_idx     <= '0;
            grp          <= '0;
            word         <= '0;
            frame_act    <= 1'b0;
            sh           <= '0;
            ads_cs_n     <= 1'b1;
            ads_start    <= 1'b0;
            ads_reset_n  <= 1'b0;
            ads_pwdn_n   <= 1'b0;
            spi.spi_req  <= 1'b0;
            spi.spi_tx   <= '0;
            init_done    <= 1'b0;
            dev_id       <= '0;
            ch_data      <= '0;
            ch_idx       <= '0;
            ch_valid     <= 1'b0;
            status       <= '0;
            overrun      <= 1'b0;
`ifdef ADS_STATUS_CHECK_EN
            stat_err     <= 1'b0;
`endif
        end else begin
            ch_valid <= 1'b0;
            cnt      <= cnt + 21'd1;
            case (state)
                IDLE: begin
                    state       <= PWR_WAIT;
                    cnt         <= '0;
                    ads_pwdn_n  <= 1'b1;
                    ads_reset_n <= 1'b1;
                end
                PWR_WAIT: begin
                    if (cnt == T_PWR - 21'd1) begin
                        state       <= RST_LOW;
                        cnt         <= '0;
                        ads_reset_n <= 1'b0;
                    end
                end
                RST_LOW: begin
                    if (cnt == T_RST_LOW - 21'd1) begin
                        state       <= RST_WAIT;
                        cnt         <= '0;
                        ads_reset_n <= 1'b1;
                    end
                end
                RST_WAIT: begin
                    if (cnt == T_RST_WAIT - 21'd1) begin
                        state    <= CFG;
                        cnt      <= '0;
                        byte_idx <= '0;
                    end
                end
                CFG: begin
                    if (gap_hit) begin
                        spi.spi_req <= 1'b1;
                        spi.spi_tx  <= rom_dat;
                        ads_cs_n    <= 1'b0;
                    end else if (xfer_done) begin
                        spi.spi_req <= 1'b0;
                        cnt         <= '0;
                        if (byte_idx == LAST_ROM) begin
                            ads_cs_n <= 1'b1;
                            state    <= ID_RD;
                            byte_idx <= '0;
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                        end
                    end
                end
                ID_RD: begin
                    // Dummy byte clocks out the ID, then RDATAC arms continuous read
                    if (gap_hit) begin
                        spi.spi_req <= 1'b1;
                        spi.spi_tx  <= (byte_idx == 5'd0) ? 8'h00 : RDATAC;
                        ads_cs_n    <= 1'b0;
                    end else if (xfer_done) begin
                        spi.spi_req <= 1'b0;
                        cnt         <= '0;
                        if (byte_idx == 5'd0) begin
                            dev_id   <= spi.spi_rx;
                            byte_idx <= 5'd1;
                        end else begin
                            ads_cs_n <= 1'b1;
                            state    <= START;
                        end
                    end
                end
                START: begin
                    ads_start <= 1'b1;
                    init_done <= 1'b1;
                    state     <= RUN;
                    cnt       <= '0;
                    byte_idx  <= '0;
                end
                RUN: begin
                    if (drdy_fall) begin
                        if (frame_act) begin
                            overrun <= 1'b1;
                        end else begin
                            frame_act   <= 1'b1;
                            byte_idx    <= '0;
                            grp         <= '0;
                            word        <= '0;
                            spi.spi_req <= 1'b1;
                            spi.spi_tx  <= 8'h00;
                            ads_cs_n    <= 1'b0;
                        end
                    end
                    if (frame_act) begin
                        if (gap_hit) begin
                            spi.spi_req <= 1'b1;
                            spi.spi_tx  <= 8'h00;
                        end else if (xfer_done) begin
                            spi.spi_req <= 1'b0;
                            cnt         <= '0;
                            sh          <= {sh[7:0], spi.spi_rx};
                            byte_idx    <= byte_idx + 5'd1;
                            if (grp == 2'd2) begin
                                grp  <= '0;
                                word <= word + 4'd1;
                                if (word == 4'd0) begin
                                    status <= {sh, spi.spi_rx};
`ifdef ADS_STATUS_CHECK_EN
                                    if (sh[15:12] != STAT_HDR) stat_err <= 1'b1;
`endif
                                end else begin
                                    ch_data  <= {sh, spi.spi_rx};
                                    ch_idx   <= 3'(word - 4'd1);
                                    ch_valid <= 1'b1;
                                end
                            end else begin
                                grp <= grp + 2'd1;
                            end
                            if (byte_idx == LAST_FB) begin
                                frame_act <= 1'b0;
                                ads_cs_n  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ads_cfg_seq.md
ADS_CFG_SEQ -- requirements
Module: ads_cfg_seq

Interface
REQ-001 Parameters (name, default, meaning): T_PWR 21'h1FFFFF, power-up settle cycles; T_RST_LOW 21'h100, RESET low cycles; T_RST_WAIT 21'h10000, post-reset wait cycles; BYTE_GAP 16, idle cycles between bytes; FRAME_BYTES 27, bytes per data frame.
REQ-002 Ports (name direction width meaning): clk_50M in 1 system clock; rst in 1 reset, asynchronous, active-high.
REQ-003 ads_drdy_n in 1 DRDY from ADC (async); ads_cs_n out 1 chip select; ads_start out 1 START pin; ads_reset_n out 1 RESET pin; ads_pwdn_n out 1 PWDN pin.
REQ-004 spi_req out 1 byte transfer request; spi_tx out 8 byte to send; spi_done in 1 one-cycle transfer-complete pulse; spi_rx in 8 received byte, valid with spi_done.
REQ-005 init_done out 1 sequence complete; dev_id out 8 ID register readback; ch_data out 24 channel sample; ch_idx out 3 channel number; ch_valid out 1 one-cycle sample strobe; status out 24 frame status word; overrun out 1 sticky missed-frame flag.

Function
REQ-006 States: IDLE, PWR_WAIT, RST_LOW, RST_WAIT, CFG, ID_RD, START, RUN; encoding held in shared package.
REQ-007 IDLE -> PWR_WAIT unconditionally one cycle after reset release; PWR_WAIT drives ads_pwdn_n=1, ads_reset_n=1 for T_PWR cycles.
REQ-008 RST_LOW drives ads_reset_n=0 for T_RST_LOW cycles; RST_WAIT drives ads_reset_n=1 for T_RST_WAIT cycles, then CFG.
REQ-009 One 21-bit cycle counter, cleared on every state entry; transition fires on the cycle counter equals parameter minus 1.
REQ-010 CFG sends 18 ROM bytes in order: 11,41,02,D6,E3,40,45,07,10,10,10,10,10,10,10,10,20,00 (hex); ads_cs_n low from first request to last spi_done.
REQ-011 Byte handshake: spi_req asserted with stable spi_tx until spi_done; spi_req low the cycle after spi_done; next request after exactly BYTE_GAP idle cycles.
REQ-012 ID_RD sends one 00 byte, latches spi_rx into dev_id, then sends ROM byte 10 (RDATAC), then raises ads_cs_n.
REQ-013 START drives ads_start=1 (held thereafter), asserts init_done (held until reset), enters RUN next cycle.
REQ-014 ads_drdy_n passes a 2-flop synchroniser; falling edge detected on synchronised signal.
REQ-015 RUN: on DRDY fall with no frame active, ads_cs_n low, FRAME_BYTES transfers of 00 issued per REQ-011, ads_cs_n high after last spi_done.
REQ-016 Bytes 0-2 assemble status (MSB first), updated after byte 2; bytes 3k..3k+2 assemble ch_data, ch_idx=k-1, ch_valid one cycle after third byte's spi_done.
REQ-017 DRDY fall during an active frame is ignored and sets overrun; overrun clears only on reset.
REQ-018 DRDY edges outside RUN ignored and do not set overrun.
REQ-019 spi_done while spi_req low is ignored.

Reset
REQ-020 rst asynchronously forces IDLE, counter 0, ads_cs_n=1, ads_start=0, ads_reset_n=0, ads_pwdn_n=0, spi_req=0, spi_tx=0, init_done=0, dev_id=0, ch_data=0, ch_idx=0, ch_valid=0, status=0, overrun=0.
REQ-021 Reset mid-transfer or mid-frame abandons it immediately; no partial ch_valid afterwards; full sequence restarts from IDLE.

Configuration
REQ-022 Macro ADS_STATUS_CHECK_EN defined: extra output stat_err (1 bit, reset 0), set sticky when status[23:20] != 4'hC after byte 2 of any frame.
REQ-023 Macro undefined: stat_err port and check logic absent; all other behaviour identical.

Structure
REQ-024 Package ads_pkg: state enum, opcodes SDATAC=11, RDATAC=10, WREG, RREG, ROM length 18, status header 4'hC.
REQ-025 Sub-module ads_cfg_rom: 5-bit index in, 8-bit byte out, combinational; all other logic in ads_cfg_seq.

Verification
REQ-026 T_PWR=100, T_RST_LOW=10, T_RST_WAIT=50: ads_reset_n low exactly 10 cycles starting cycle 101 after reset release.
REQ-027 SPI model with 8-cycle done latency: 18 CFG bytes observed in ROM order, gaps exactly 16 cycles, ads_cs_n low throughout.
REQ-028 Model returns D2 on ID_RD dummy byte: dev_id=D2, then byte 10 sent, ads_start and init_done rise.
REQ-029 RUN, one DRDY fall, rx stream C00000 then 000001..000008: status=C00000, eight ch_valid pulses, ch_idx 0..7, ch_data 1..8.
REQ-030 Second DRDY fall at frame byte 10: frame completes unchanged, overrun=1; rst mid-frame: all outputs at reset values, ch_valid silent.
